pdm_record_controller: RTL and testbench
========================================

// Module: pdm_record_controller
// PURPOSE
//  Sequences the PDM deserializer for one recording pass and streams its 16-bit words into sample memory.
//  Sits between the top-level controller (start/stop) and the deserializer + sample RAM.
//  Owns the deserializer enable, discards the first (misaligned) word, and buffers one word against memory stalls.
//  Terminates after RECORD_WORDS words or on stop_i, then drains.
// PARAMETERS
//  WORD_LENGTH   16     deserializer word width (bits)
//  ADDR_WIDTH    16     sample memory address width
//  RECORD_WORDS  65536  words stored per pass; legal range 1..2**ADDR_WIDTH
// PORTS
//  clock_i        in   1              100 MHz system clock
//  reset_i        in   1              asynchronous, active-high reset
//  start_i        in   1              one-cycle pulse; begins a pass (honoured in IDLE only)
//  stop_i         in   1              one-cycle pulse; early termination (ignored in IDLE/DRAIN/DONE)
//  deser_enable_o out  1              enable to deserializer (its ~reset)
//  deser_done_i   in   1              deserializer word-ready level, PDM-clock domain
//  deser_data_i   in   WORD_LENGTH    deserializer word, stable while deser_done_i high
//  mem_we_o       out  1              write request; held until accepted
//  mem_addr_o     out  ADDR_WIDTH     write address
//  mem_data_o     out  WORD_LENGTH    write data
//  mem_ready_i    in   1              memory accepts write this cycle when high with mem_we_o
//  busy_o         out  1              high in every state except IDLE
//  done_o         out  1              one-cycle pulse at end of pass
//  word_count_o   out  ADDR_WIDTH+1   words accepted by memory this pass
//  overrun_o      out  1              sticky: a word was dropped this pass
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; holding reg empty; sync flops 0.
//  deser_done_i passes through 2-FF synchronizer + edge detector; "word event" = synced rising edge.
//  Latency: deser_done_i first sampled high at edge k -> holding reg loaded and mem_we_o high after edge k+3.
//  deser_data_i sampled on the word-event cycle (PDM period >= 8 system clocks guarantees stability).
//  FSM:
//   IDLE   : start_i -> PRIME; clears word_count_o, overrun_o, mem_addr_o.
//   PRIME  : deser_enable_o=1; first word event discarded -> RECORD; stop_i -> DONE.
//   RECORD : deser_enable_o=1; each word event loads holding reg (valid=1).
//            word_count_o + pending valid == RECORD_WORDS, or stop_i -> DRAIN.
//   DRAIN  : deser_enable_o=0; word events ignored; holding reg empty -> DONE.
//   DONE   : done_o=1 for exactly this cycle -> IDLE.
//  Memory handshake: mem_we_o == valid; on mem_we_o&&mem_ready_i: valid clears,
//   word_count_o+1, mem_addr_o+1 (wraps to 0 when RECORD_WORDS==2**ADDR_WIDTH).
//  mem_addr_o/mem_data_o hold stable while mem_we_o high and not accepted.
//  Word event while valid and no accept same cycle: new word dropped, overrun_o<=1 (sticky to next start).
//  Word event with accept same cycle: new word loaded, valid stays 1, no overrun.
//  Words counted toward RECORD_WORDS only on load; no more loads once limit reached.
//  start_i outside IDLE ignored; start_i and stop_i together in IDLE: start honoured.
//  stop_i during RECORD with valid=1: pending word still written in DRAIN.
//  Reset mid-pass: immediate return to IDLE, deser_enable_o and mem_we_o drop asynchronously.
// TESTING
//  1. RECORD_WORDS=4, mem_ready_i=1, 6 deser words -> word 0 dropped, words 1-4 at addr 0-3, done_o 1 pulse, count=4.
//  2. mem_ready_i low 2 words' duration -> one word kept, next dropped, overrun_o=1, kept word written at next addr.
//  3. Word event in cycle of accept -> both words written back-to-back, overrun_o=0.
//  4. stop_i in PRIME -> DONE next cycle, word_count_o=0, no mem_we_o; stop_i in RECORD w/ pending -> pending written, done.
//  5. reset_i asserted mid-RECORD w/ mem_we_o high -> all outputs 0 without clock edge; new start restarts addr 0.
//  6. RECORD_WORDS=2**ADDR_WIDTH (small ADDR_WIDTH=3) -> 8 writes addr 0-7, count=8, mem_addr_o wraps to 0.

Source files
------------

// File: rtl/pdm_record_controller.sv
// Record-pass sequencer: enables the PDM deserializer, drops its first (misaligned)
// word, and streams the following words through a one-word holding register into sample memory.
module pdm_record_controller #(
  parameter int WORD_LENGTH  = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int RECORD_WORDS = 65536
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  output logic                   deser_enable_o,
  input  logic                   deser_done_i,
  input  logic [WORD_LENGTH-1:0] deser_data_i,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [WORD_LENGTH-1:0] mem_data_o,
  input  logic                   mem_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [ADDR_WIDTH:0]    word_count_o,
  output logic                   overrun_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RECORD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [ADDR_WIDTH+1:0] LIMIT     = (ADDR_WIDTH+2)'(RECORD_WORDS);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                  state_q;
  state_t                  state_d;

  logic                    done_meta_q;
  logic                    done_sync_q;
  logic                    done_prev_q;
  logic                    word_event_q;

  logic                    valid_q;
  logic [WORD_LENGTH-1:0]  hold_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    overrun_q;

  logic                    in_record;
  logic                    start_pass;
  logic                    accept;
  logic [ADDR_WIDTH+1:0]   pending_total;
  logic                    limit_reached;
  logic                    load_en;
  logic                    drop_en;

  // deser_done_i is in the PDM clock domain: two-flop synchronizer, then a
  // registered rising-edge pulse so data is sampled well after it settled.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      done_meta_q  <= 1'b0;
      done_sync_q  <= 1'b0;
      done_prev_q  <= 1'b0;
      word_event_q <= 1'b0;
    end else begin
      done_meta_q  <= deser_done_i;
      done_sync_q  <= done_meta_q;
      done_prev_q  <= done_sync_q;
      word_event_q <= done_sync_q & ~done_prev_q;
    end
  end

  // Memory handshake: mem_we_o is the holding register's valid bit; a word
  // transfers on any cycle where mem_we_o && mem_ready_i, and address/data
  // stay frozen until that happens.
  assign accept        = valid_q & mem_ready_i;
  assign in_record     = (state_q == ST_RECORD);
  assign start_pass    = (state_q == ST_IDLE) & start_i;
  assign pending_total = {1'b0, count_q} + {{(ADDR_WIDTH+1){1'b0}}, valid_q};
  assign limit_reached = (pending_total == LIMIT);
  assign load_en       = in_record & word_event_q & ~limit_reached & (~valid_q | accept);
  assign drop_en       = in_record & word_event_q & ~limit_reached & valid_q & ~accept;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else if (load_en) begin
      valid_q <= 1'b1;
      hold_q  <= deser_data_i;
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q   <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else if (start_pass) begin
      count_q   <= '0;
      addr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        count_q <= count_q + COUNT_ONE;
        addr_q  <= addr_q + ADDR_ONE;
      end
      if (drop_en) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (stop_i)            state_d = ST_DONE;
        else if (word_event_q) state_d = ST_RECORD;
      end
      ST_RECORD: begin
        if (limit_reached || stop_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    deser_enable_o = (state_q == ST_PRIME) || (state_q == ST_RECORD);
    busy_o         = (state_q != ST_IDLE);
    done_o         = (state_q == ST_DONE);
  end

  assign mem_we_o     = valid_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = hold_q;
  assign word_count_o = count_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_pdm_record_controller.sv
// Bench for pdm_record_controller: two instances (4-word pass, and 3-bit address
// with a full 8-word pass) checked every cycle against a behavioural pass model.
module tb_pdm_record_controller;
  localparam int WL   = 16;
  localparam int AW_A = 16;
  localparam int RW_A = 4;
  localparam int AW_B = 3;
  localparam int RW_B = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic          stop = 1'b0;
  logic          deser_done = 1'b0;
  logic [WL-1:0] deser_data = '0;
  logic          mem_ready = 1'b0;

  logic            en_a, we_a, busy_a, done_a, ovr_a;
  logic [AW_A-1:0] addr_a;
  logic [WL-1:0]   data_a;
  logic [AW_A:0]   cnt_a;
  logic            en_b, we_b, busy_b, done_b, ovr_b;
  logic [AW_B-1:0] addr_b;
  logic [WL-1:0]   data_b;
  logic [AW_B:0]   cnt_b;

  pdm_record_controller #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW_A), .RECORD_WORDS(RW_A)) dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(start_a), .stop_i(stop),
    .deser_enable_o(en_a), .deser_done_i(deser_done), .deser_data_i(deser_data),
    .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_data_o(data_a), .mem_ready_i(mem_ready),
    .busy_o(busy_a), .done_o(done_a), .word_count_o(cnt_a), .overrun_o(ovr_a)
  );

  pdm_record_controller #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW_B), .RECORD_WORDS(RW_B)) dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(start_b), .stop_i(stop),
    .deser_enable_o(en_b), .deser_done_i(deser_done), .deser_data_i(deser_data),
    .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_data_o(data_b), .mem_ready_i(mem_ready),
    .busy_o(busy_b), .done_o(done_b), .word_count_o(cnt_b), .overrun_o(ovr_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of one recording pass per instance
  typedef enum int {M_IDLE, M_PRIME, M_RECORD, M_DRAIN, M_DONE} mphase_t;
  mphase_t       m_phase[2];
  logic          m_valid[2];
  int            m_count[2];
  int            m_addr[2];
  logic          m_over[2];
  logic [3:0]    hist;
  logic [WL-1:0] exp_q0[$];
  logic [WL-1:0] exp_q1[$];
  int            la0[$], ld0[$], la1[$], ld1[$];
  int            done_cnt[2];

  function automatic int rw_of(input int i);
    return (i == 0) ? RW_A : RW_B;
  endfunction

  function automatic int aw_of(input int i);
    return (i == 0) ? AW_A : AW_B;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = M_IDLE;
      m_valid[i] = 1'b0;
      m_count[i] = 0;
      m_addr[i]  = 0;
      m_over[i]  = 1'b0;
    end
    hist = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_step(input int i, input logic st, input logic ev, input logic [WL-1:0] d);
    logic acc, lim, loaded;
    acc    = m_valid[i] && mem_ready;
    lim    = (m_count[i] + int'(m_valid[i])) == rw_of(i);
    loaded = 1'b0;
    case (m_phase[i])
      M_IDLE: if (st) begin
        m_phase[i] = M_PRIME;
        m_count[i] = 0;
        m_addr[i]  = 0;
        m_over[i]  = 1'b0;
      end
      M_PRIME: begin
        if (stop)    m_phase[i] = M_DONE;
        else if (ev) m_phase[i] = M_RECORD;
      end
      M_RECORD: begin
        if (ev && !lim) begin
          if (m_valid[i] && !acc) m_over[i] = 1'b1;
          else begin
            loaded = 1'b1;
            if (i == 0) exp_q0.push_back(d);
            else        exp_q1.push_back(d);
          end
        end
        if (lim || stop) m_phase[i] = M_DRAIN;
      end
      M_DRAIN: if (!m_valid[i]) m_phase[i] = M_DONE;
      default: m_phase[i] = M_IDLE;
    endcase
    if (acc) begin
      m_count[i]++;
      m_addr[i] = (m_addr[i] + 1) % (1 << aw_of(i));
    end
    if (loaded)   m_valid[i] = 1'b1;
    else if (acc) m_valid[i] = 1'b0;
  endtask

  // a word event fires three edges after deser_done is first sampled high
  initial begin
    logic ev;
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        ev = hist[2] & ~hist[3];
        model_step(0, start_a, ev, deser_data);
        model_step(1, start_b, ev, deser_data);
        hist = {hist[2:0], deser_done};
      end
    end
  end

  // scoreboard / compare process
  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("a_busy",  busy_a, m_phase[0] != M_IDLE);
        check("a_done",  done_a, m_phase[0] == M_DONE);
        check("a_en",    en_a, m_phase[0] == M_PRIME || m_phase[0] == M_RECORD);
        check("a_we",    we_a, m_valid[0]);
        check("a_count", cnt_a, m_count[0]);
        check("a_addr",  addr_a, m_addr[0]);
        check("a_ovr",   ovr_a, m_over[0]);
        check("b_busy",  busy_b, m_phase[1] != M_IDLE);
        check("b_done",  done_b, m_phase[1] == M_DONE);
        check("b_en",    en_b, m_phase[1] == M_PRIME || m_phase[1] == M_RECORD);
        check("b_we",    we_b, m_valid[1]);
        check("b_count", cnt_b, m_count[1]);
        check("b_addr",  addr_b, m_addr[1]);
        check("b_ovr",   ovr_b, m_over[1]);
        if (done_a) done_cnt[0]++;
        if (done_b) done_cnt[1]++;
        if (we_a && mem_ready) begin
          la0.push_back(int'(addr_a));
          ld0.push_back(int'(data_a));
          if (exp_q0.size() == 0) check("a_sb_extra_write", 1, 0);
          else check("a_sb_data", data_a, exp_q0.pop_front());
        end
        if (we_b && mem_ready) begin
          la1.push_back(int'(addr_b));
          ld1.push_back(int'(data_b));
          if (exp_q1.size() == 0) check("b_sb_extra_write", 1, 0);
          else check("b_sb_data", data_b, exp_q1.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    if (i == 0) start_a = 1'b1; else start_b = 1'b1;
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic send_word(input logic [WL-1:0] d);
    deser_data = d;
    deser_done = 1'b1;
    tick(4);
    deser_done = 1'b0;
    tick(6);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int c;
    c = 0;
    while (((i == 0) ? busy_a : busy_b) && c < budget) begin
      tick(1);
      c++;
    end
    check((i == 0) ? "a_idle_timeout" : "b_idle_timeout", (i == 0) ? busy_a : busy_b, 0);
  endtask

  task automatic clear_logs();
    la0.delete(); ld0.delete(); la1.delete(); ld1.delete();
  endtask

  task automatic check_log(input int i, input int n, input int first_addr, input int first_data, input int data_step);
    int sz;
    sz = (i == 0) ? la0.size() : la1.size();
    check((i == 0) ? "a_log_len" : "b_log_len", sz, n);
    for (int j = 0; j < n && j < sz; j++) begin
      check((i == 0) ? "a_log_addr" : "b_log_addr", (i == 0) ? la0[j] : la1[j],
            (first_addr + j) % (1 << aw_of(i)));
      check((i == 0) ? "a_log_data" : "b_log_data", (i == 0) ? ld0[j] : ld1[j],
            first_data + j * data_step);
    end
  endtask

  initial begin
    int d0, d1;
    // reset state
    tick(2);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_we", we_a, 0);
    check("rst_a_en", en_a, 0);
    check("rst_b_count", cnt_b, 0);
    check("rst_b_done", done_b, 0);
    rst = 1'b0;
    tick(2);

    // 4-word pass, memory always ready, 6 words offered
    clear_logs();
    d0 = done_cnt[0];
    mem_ready = 1'b1;
    pulse_start(0);
    check("t1_en_prime", en_a, 1);
    for (int i = 0; i < 6; i++) send_word(16'hA000 + 16'(i));
    wait_idle(0, 50);
    check_log(0, 4, 0, 'hA001, 1);
    check("t1_count", cnt_a, 4);
    check("t1_addr", addr_a, 4);
    check("t1_ovr", ovr_a, 0);
    check("t1_done_pulses", done_cnt[0] - d0, 1);

    // memory stalls across two words: one kept, one dropped
    clear_logs();
    d1 = done_cnt[1];
    mem_ready = 1'b0;
    pulse_start(1);
    send_word(16'hB000);
    send_word(16'hB001);
    send_word(16'hB002);
    check("t2_ovr_set", ovr_b, 1);
    mem_ready = 1'b1;
    tick(2);
    send_word(16'hB003);
    pulse_stop();
    wait_idle(1, 50);
    check_log(1, 2, 0, 'hB001, 2);
    check("t2_ovr_sticky", ovr_b, 1);
    check("t2_count", cnt_b, 2);
    check("t2_done_pulses", done_cnt[1] - d1, 1);

    // word event in the same cycle as an accept
    clear_logs();
    mem_ready = 1'b0;
    pulse_start(1);
    check("t3_ovr_cleared", ovr_b, 0);
    send_word(16'hC000);
    send_word(16'hC001);
    deser_data = 16'hC002;
    deser_done = 1'b1;
    tick(3);
    mem_ready = 1'b1;
    tick(1);
    check("t3_we_reloaded", we_b, 1);
    check("t3_data_next", data_b, 16'hC002);
    deser_done = 1'b0;
    tick(6);
    pulse_stop();
    wait_idle(1, 50);
    check_log(1, 2, 0, 'hC001, 1);
    check("t3_ovr", ovr_b, 0);

    // stop in PRIME, then stop in RECORD with a pending word
    clear_logs();
    d0 = done_cnt[0];
    pulse_start(0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t4_done_now", done_a, 1);
    check("t4_count0", cnt_a, 0);
    check("t4_no_we", we_a, 0);
    tick(1);
    check("t4_idle", busy_a, 0);
    mem_ready = 1'b0;
    pulse_start(0);
    send_word(16'hD000);
    send_word(16'hD001);
    pulse_stop();
    tick(3);
    check("t4_drain_we", we_a, 1);
    check("t4_drain_en", en_a, 0);
    mem_ready = 1'b1;
    wait_idle(0, 50);
    check_log(0, 1, 0, 'hD001, 1);
    check("t4_count", cnt_a, 1);
    check("t4_done_pulses", done_cnt[0] - d0, 2);

    // asynchronous reset mid-RECORD with a write pending
    mem_ready = 1'b1;
    pulse_start(1);
    send_word(16'hE000);
    send_word(16'hE001);
    mem_ready = 1'b0;
    send_word(16'hE002);
    check("t5_pre_we", we_b, 1);
    check("t5_pre_addr", addr_b, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy_b, 0);
    check("t5_rst_en", en_b, 0);
    check("t5_rst_we", we_b, 0);
    check("t5_rst_count", cnt_b, 0);
    check("t5_rst_addr", addr_b, 0);
    check("t5_rst_data", data_b, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    clear_logs();
    mem_ready = 1'b1;
    pulse_start(1);
    send_word(16'hE100);
    send_word(16'hE101);
    pulse_stop();
    wait_idle(1, 50);
    check_log(1, 1, 0, 'hE101, 1);

    // full address space on the 3-bit instance: wrap to 0
    clear_logs();
    d1 = done_cnt[1];
    pulse_start(1);
    for (int i = 0; i < 10; i++) send_word(16'hF000 + 16'(i));
    wait_idle(1, 50);
    check_log(1, 8, 0, 'hF001, 1);
    check("t6_count", cnt_b, 8);
    check("t6_addr_wrap", addr_b, 0);
    check("t6_done_pulses", done_cnt[1] - d1, 1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
